// File: rtl/reset_seq_pkg.sv
// -----------------------------------------------------------------------------
// reset_seq_pkg
// Shared definitions for the reset sequencer:
//   - default parameter values
//   - active levels for all reset outputs
//   - FSM state encoding (3-bit)
//   - packed bundle of the registered sequencer outputs and its decoder
// -----------------------------------------------------------------------------
package reset_seq_pkg;

  localparam int DCM_RST_CYC_DEF  = 8;
  localparam int LOCK_TIMEOUT_DEF = 1024;
  localparam int LOCK_FILT_DEF    = 4;
  localparam int STAGE_DLY_DEF    = 16;
  localparam int MAX_RETRY_DEF    = 3;

  // All resets driven by the sequencer are active-high.
  localparam logic RST_ON  = 1'b1;
  localparam logic RST_OFF = 1'b0;

  typedef enum logic [2:0] {
    ST_ASSERT_DCM = 3'd0,
    ST_WAIT_LOCK  = 3'd1,
    ST_REL_BUS    = 3'd2,
    ST_REL_CPU    = 3'd3,
    ST_RUN        = 3'd4,
    ST_SOFT_HOLD  = 3'd5,
    ST_FAIL       = 3'd6
  } state_t;

  typedef struct packed {
    logic dcm_reset;
    logic bus_reset;
    logic cpu_reset;
    logic io_reset;
    logic seq_ready;
    logic lock_fail;
  } seq_out_t;

  // Output decode for a given state. Domain resets are released cumulatively,
  // so io released implies cpu released implies bus released.
  function automatic seq_out_t decode_outputs(input state_t st);
    seq_out_t o;
    o.dcm_reset = RST_OFF;
    o.bus_reset = RST_ON;
    o.cpu_reset = RST_ON;
    o.io_reset  = RST_ON;
    o.seq_ready = 1'b0;
    o.lock_fail = 1'b0;
    case (st)
      ST_ASSERT_DCM: o.dcm_reset = RST_ON;
      ST_WAIT_LOCK:  ;
      ST_REL_BUS:    o.bus_reset = RST_OFF;
      ST_REL_CPU: begin
        o.bus_reset = RST_OFF;
        o.cpu_reset = RST_OFF;
      end
      ST_RUN: begin
        o.bus_reset = RST_OFF;
        o.cpu_reset = RST_OFF;
        o.io_reset  = RST_OFF;
        o.seq_ready = 1'b1;
      end
      ST_SOFT_HOLD:  ;
      ST_FAIL:       o.lock_fail = 1'b1;
      // Unused encoding: hold everything in reset, including the DCM.
      default:       o.dcm_reset = RST_ON;
    endcase
    return o;
  endfunction

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/reset_seq_cdc_sync.sv
// -----------------------------------------------------------------------------
// reset_seq_cdc_sync
// Two-flop synchronizer bringing an asynchronous level into the clk domain.
// Output lags the input by two clk edges. Flops clear on synchronous reset.
// Ports:
//   clk      in            destination clock
//   reset    in            synchronous active-high reset
//   d_async  in  [WIDTH]   asynchronous input level(s)
//   q_sync   out [WIDTH]   synchronized level(s)
// -----------------------------------------------------------------------------
module reset_seq_cdc_sync #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d_async,
  output logic [WIDTH-1:0] q_sync
);

  logic [WIDTH-1:0] meta_d, meta_q;
  logic [WIDTH-1:0] sync_d, sync_q;

  always_comb begin
    meta_d = d_async;
    sync_d = meta_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q_sync = sync_q;

endmodule

// File: rtl/reset_seq.sv
// -----------------------------------------------------------------------------
// reset_seq
// Reset sequencer between the clock generator and the core/bus/IO blocks.
// Pulses the DCM reset, waits for a filtered lock, then releases the bus, cpu
// and io domain resets STAGE_DLY cycles apart. Retries lock on timeout and
// reports lock_fail after MAX_RETRY failed attempts. Lock loss re-runs the
// whole sequence; a soft reset request re-stages the domains without touching
// the DCM.
// Ports:
//   clk           in   system clock
//   reset         in   synchronous active-high global reset
//   locked_async  in   DCM lock, asynchronous to clk
//   soft_rst_req  in   single-cycle soft reset request
//   dcm_reset     out  DCM reset (active-high)
//   bus_reset     out  bus domain reset (active-high)
//   cpu_reset     out  cpu domain reset (active-high)
//   io_reset      out  io domain reset (active-high)
//   seq_ready     out  high only in RUN
//   lock_fail     out  high only in FAIL
//   retry_cnt     out  [2] failed lock attempts in the current sequence
// -----------------------------------------------------------------------------
module reset_seq #(
  parameter int DCM_RST_CYC  = 8,
  parameter int LOCK_TIMEOUT = 1024,
  parameter int LOCK_FILT    = 4,
  parameter int STAGE_DLY    = 16,
  parameter int MAX_RETRY    = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       locked_async,
  input  logic       soft_rst_req,
  output logic       dcm_reset,
  output logic       bus_reset,
  output logic       cpu_reset,
  output logic       io_reset,
  output logic       seq_ready,
  output logic       lock_fail,
  output logic [1:0] retry_cnt
);

  import reset_seq_pkg::*;

  localparam int CNT_MAX = max4(DCM_RST_CYC, LOCK_TIMEOUT, LOCK_FILT, STAGE_DLY);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  // Terminal values: a counter sitting at LAST on an edge means N cycles done.
  localparam logic [CNT_W-1:0] DCM_LAST   = CNT_W'(DCM_RST_CYC - 1);
  localparam logic [CNT_W-1:0] TMO_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] FILT_LAST  = CNT_W'(LOCK_FILT - 1);
  localparam logic [CNT_W-1:0] STAGE_LAST = CNT_W'(STAGE_DLY - 1);
  localparam logic [1:0]       RETRY_MAX  = 2'(MAX_RETRY);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic             lock_s;
  state_t           state_d, state_q;
  logic [CNT_W-1:0] dly_d, dly_q;
  logic [CNT_W-1:0] filt_d, filt_q;
  logic [CNT_W-1:0] tmo_d, tmo_q;
  logic [1:0]       retry_d, retry_q;
  logic [1:0]       retry_inc;
  seq_out_t         out_d, out_q;

  reset_seq_cdc_sync #(
    .WIDTH (1)
  ) u_lock_sync (
    .clk     (clk),
    .reset   (reset),
    .d_async (locked_async),
    .q_sync  (lock_s)
  );

  assign retry_inc = (retry_q == 2'b11) ? retry_q : retry_q + 2'd1;

  // Next-state and counter logic. Priority inside the active states is
  // lock loss, then soft request, then delay expiry. Every state change
  // clears the shared delay counter so each state starts its own count.
  always_comb begin
    state_d = state_q;
    dly_d   = dly_q;
    filt_d  = filt_q;
    tmo_d   = tmo_q;
    retry_d = retry_q;

    case (state_q)
      ST_ASSERT_DCM: begin
        if (dly_q == DCM_LAST) begin
          state_d = ST_WAIT_LOCK;
          dly_d   = '0;
          filt_d  = '0;
          tmo_d   = '0;
        end else begin
          dly_d = sat_inc(dly_q);
        end
      end

      ST_WAIT_LOCK: begin
        filt_d = lock_s ? sat_inc(filt_q) : '0;
        tmo_d  = sat_inc(tmo_q);
        // Lock completion takes precedence over a coincident timeout.
        if (lock_s && (filt_q == FILT_LAST)) begin
          state_d = ST_REL_BUS;
          dly_d   = '0;
        end else if (tmo_q == TMO_LAST) begin
          retry_d = retry_inc;
          dly_d   = '0;
          state_d = (retry_inc == RETRY_MAX) ? ST_FAIL : ST_ASSERT_DCM;
        end
      end

      ST_REL_BUS, ST_REL_CPU, ST_RUN, ST_SOFT_HOLD: begin
        if (!lock_s) begin
          // Lock loss restarts from the DCM and is not a failed attempt.
          state_d = ST_ASSERT_DCM;
          dly_d   = '0;
          retry_d = '0;
        end else if (soft_rst_req) begin
          // Also restarts the hold count when already in SOFT_HOLD.
          state_d = ST_SOFT_HOLD;
          dly_d   = '0;
        end else if (state_q != ST_RUN) begin
          if (dly_q == STAGE_LAST) begin
            dly_d = '0;
            case (state_q)
              ST_REL_BUS: state_d = ST_REL_CPU;
              ST_REL_CPU: state_d = ST_RUN;
              default:    state_d = ST_REL_BUS;
            endcase
          end else begin
            dly_d = sat_inc(dly_q);
          end
        end
      end

      ST_FAIL: begin
        if (soft_rst_req) begin
          state_d = ST_ASSERT_DCM;
          dly_d   = '0;
          retry_d = '0;
        end
      end

      default: begin
        state_d = ST_ASSERT_DCM;
        dly_d   = '0;
        retry_d = '0;
      end
    endcase

    // Outputs follow the next state so they switch on the same edge as it.
    out_d = decode_outputs(state_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_ASSERT_DCM;
      dly_q   <= '0;
      filt_q  <= '0;
      tmo_q   <= '0;
      retry_q <= '0;
      out_q   <= decode_outputs(ST_ASSERT_DCM);
    end else begin
      state_q <= state_d;
      dly_q   <= dly_d;
      filt_q  <= filt_d;
      tmo_q   <= tmo_d;
      retry_q <= retry_d;
      out_q   <= out_d;
    end
  end

  assign dcm_reset = out_q.dcm_reset;
  assign bus_reset = out_q.bus_reset;
  assign cpu_reset = out_q.cpu_reset;
  assign io_reset  = out_q.io_reset;
  assign seq_ready = out_q.seq_ready;
  assign lock_fail = out_q.lock_fail;
  assign retry_cnt = retry_q;

endmodule

// File: tb/tb_reset_seq.sv
// -----------------------------------------------------------------------------
// tb_reset_seq
// Scoreboard bench for reset_seq with default parameters. The stimulus
// process pushes every expected output transition (cycle stamp + output
// vector) into a queue; the monitor pops one entry each time the DUT output
// vector changes and compares value and cycle.
// Output vector layout: {dcm, bus, cpu, io, ready, fail, retry[1:0]}.
// -----------------------------------------------------------------------------
module tb_reset_seq;

  logic       clk = 1'b0;
  logic       reset;
  logic       locked_async;
  logic       soft_rst_req;
  logic       dcm_reset, bus_reset, cpu_reset, io_reset;
  logic       seq_ready, lock_fail;
  logic [1:0] retry_cnt;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;

  typedef struct {
    int         cyc;
    logic [7:0] val;
    string      name;
  } exp_t;

  exp_t sb[$];

  localparam logic [7:0] V_DCM0  = 8'b1111_0000;
  localparam logic [7:0] V_DCM1  = 8'b1111_0001;
  localparam logic [7:0] V_DCM2  = 8'b1111_0010;
  localparam logic [7:0] V_WAIT0 = 8'b0111_0000;
  localparam logic [7:0] V_WAIT1 = 8'b0111_0001;
  localparam logic [7:0] V_WAIT2 = 8'b0111_0010;
  localparam logic [7:0] V_HOLD  = 8'b0111_0000;
  localparam logic [7:0] V_BUS   = 8'b0011_0000;
  localparam logic [7:0] V_CPU   = 8'b0001_0000;
  localparam logic [7:0] V_RUN   = 8'b0000_1000;
  localparam logic [7:0] V_FAIL3 = 8'b0111_0111;

  reset_seq dut (
    .clk          (clk),
    .reset        (reset),
    .locked_async (locked_async),
    .soft_rst_req (soft_rst_req),
    .dcm_reset    (dcm_reset),
    .bus_reset    (bus_reset),
    .cpu_reset    (cpu_reset),
    .io_reset     (io_reset),
    .seq_ready    (seq_ready),
    .lock_fail    (lock_fail),
    .retry_cnt    (retry_cnt)
  );

  // Free-running clock and edge counter used to stamp expectations.
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic applyStimulus(input logic r, input logic l, input logic s);
    reset        = r;
    locked_async = l;
    soft_rst_req = s;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expectAt(input int offset, input logic [7:0] val, input string name);
    exp_t e;
    e.cyc  = cyc + offset;
    e.val  = val;
    e.name = name;
    sb.push_back(e);
  endtask

  task automatic checkOutput(input exp_t e, input int got_cyc, input logic [7:0] got_val);
    tests_run++;
    if (got_cyc != e.cyc || got_val !== e.val) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %b at cycle %0d, want %b at cycle %0d",
               e.name, got_val, got_cyc, e.val, e.cyc);
    end
  endtask

  // Monitor: every change of the output vector consumes one expectation and
  // is also checked against the release-order invariant.
  logic [7:0] prev_v = 'x;
  logic [7:0] cur_v;

  always @(negedge clk) begin
    cur_v = {dcm_reset, bus_reset, cpu_reset, io_reset, seq_ready, lock_fail, retry_cnt};
    if (cur_v !== prev_v) begin
      if (sb.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("[TB] FAIL unexpected_change: got %b at cycle %0d, want no change",
                 cur_v, cyc);
      end else begin
        checkOutput(sb.pop_front(), cyc, cur_v);
      end
      tests_run++;
      if ((io_reset === 1'b0 && cpu_reset !== 1'b0) ||
          (cpu_reset === 1'b0 && bus_reset !== 1'b0)) begin
        tests_failed++;
        $display("[TB] FAIL release_order: got bus/cpu/io=%b%b%b at cycle %0d, want ordered release",
                 bus_reset, cpu_reset, io_reset, cyc);
      end
      prev_v = cur_v;
    end
  end

  initial begin
    applyStimulus(1'b1, 1'b0, 1'b0);
    expectAt(1, V_DCM0, "reset_state");
    waitCycles(3);

    // Power-up: lock rises 20 cycles after reset release.
    applyStimulus(1'b0, 1'b0, 1'b0);
    expectAt(8,  V_WAIT0, "pwr_dcm_release");
    expectAt(26, V_BUS,   "pwr_bus_release");
    expectAt(42, V_CPU,   "pwr_cpu_release");
    expectAt(58, V_RUN,   "pwr_run");
    waitCycles(20);
    applyStimulus(1'b0, 1'b1, 1'b0);
    waitCycles(45);

    // Soft reset request in RUN.
    applyStimulus(1'b0, 1'b1, 1'b1);
    expectAt(1,  V_HOLD, "soft_hold");
    expectAt(17, V_BUS,  "soft_bus_release");
    expectAt(33, V_CPU,  "soft_cpu_release");
    expectAt(49, V_RUN,  "soft_run");
    waitCycles(1);
    applyStimulus(1'b0, 1'b1, 1'b0);
    waitCycles(60);

    // One-cycle lock drop in RUN.
    applyStimulus(1'b0, 1'b0, 1'b0);
    expectAt(3,  V_DCM0,  "loss_dcm_assert");
    expectAt(11, V_WAIT0, "loss_dcm_release");
    expectAt(15, V_BUS,   "loss_bus_release");
    expectAt(31, V_CPU,   "loss_cpu_release");
    expectAt(47, V_RUN,   "loss_run");
    waitCycles(1);
    applyStimulus(1'b0, 1'b1, 1'b0);
    waitCycles(55);

    // Soft request coinciding with synced lock loss: lock loss path wins.
    applyStimulus(1'b0, 1'b0, 1'b0);
    expectAt(3,  V_DCM0,  "loss_vs_soft_dcm");
    expectAt(11, V_WAIT0, "loss_vs_soft_release");
    expectAt(15, V_BUS,   "loss_vs_soft_bus");
    expectAt(31, V_CPU,   "loss_vs_soft_cpu");
    waitCycles(1);
    applyStimulus(1'b0, 1'b1, 1'b0);
    waitCycles(1);
    applyStimulus(1'b0, 1'b1, 1'b1);
    waitCycles(1);
    applyStimulus(1'b0, 1'b1, 1'b0);
    waitCycles(32);

    // Reset in the middle of REL_CPU, then a clean restart with lock high.
    applyStimulus(1'b1, 1'b1, 1'b0);
    expectAt(1, V_DCM0, "midcpu_reset");
    waitCycles(2);
    applyStimulus(1'b0, 1'b1, 1'b0);
    expectAt(8,  V_WAIT0, "restart_dcm_release");
    expectAt(12, V_BUS,   "restart_bus_release");
    expectAt(28, V_CPU,   "restart_cpu_release");
    expectAt(44, V_RUN,   "restart_run");
    waitCycles(50);

    // Lock never arrives: three timeouts, then FAIL.
    applyStimulus(1'b1, 1'b0, 1'b0);
    expectAt(1, V_DCM0, "nolock_reset");
    waitCycles(2);
    applyStimulus(1'b0, 1'b0, 1'b0);
    expectAt(8,    V_WAIT0, "nolock_dcm_release");
    expectAt(1032, V_DCM1,  "timeout1_retry");
    expectAt(1040, V_WAIT1, "timeout1_release");
    expectAt(2064, V_DCM2,  "timeout2_retry");
    expectAt(2072, V_WAIT2, "timeout2_release");
    expectAt(3096, V_FAIL3, "timeout3_fail");
    waitCycles(3100);

    // Soft request leaves FAIL with retry_cnt cleared.
    applyStimulus(1'b0, 1'b0, 1'b1);
    expectAt(1, V_DCM0,  "fail_exit");
    expectAt(9, V_WAIT0, "fail_exit_release");
    waitCycles(1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    waitCycles(8);

    // Glitchy lock: 3 high / 2 low for 500 cycles, then steady high.
    expectAt(506, V_BUS, "glitch_bus_release");
    expectAt(522, V_CPU, "glitch_cpu_release");
    expectAt(538, V_RUN, "glitch_run");
    for (int i = 0; i < 100; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0);
      waitCycles(3);
      applyStimulus(1'b0, 1'b0, 1'b0);
      waitCycles(2);
    end
    applyStimulus(1'b0, 1'b1, 1'b0);
    waitCycles(60);

    tests_run++;
    if (sb.size() != 0) begin
      tests_failed++;
      $display("[TB] FAIL scoreboard_drained: got %0d pending, want 0 (next %s at cycle %0d)",
               sb.size(), sb[0].name, sb[0].cyc);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
